// File: rtl/anspwm_pkg.sv
// Shared types and limits for the ANS-PWM residual stage.
package anspwm_pkg;

   localparam int unsigned DELAY_MAX = 8;
   localparam int unsigned MAG_W_MAX = 64;

   typedef enum logic [1:0] {
      ORDER_1 = 2'd1,
      ORDER_2 = 2'd2
   } order_e;

   typedef struct packed {
      logic                 sgn;
      logic [MAG_W_MAX-1:0] mag;
   } sgnmag_t;

endpackage

// File: rtl/anspwm_delay_line.sv
// Fixed-depth delay line carrying magnitude, sign and valid; each entry holds
// its data while the valid feeding it is low. DEPTH=0 is a plain wire.
module anspwm_delay_line
   import anspwm_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_sgn,
   input  logic             i_vld,
   output logic [WIDTH-1:0] o_data,
   output logic             o_sgn,
   output logic             o_vld
);

   generate
      if (DEPTH > DELAY_MAX) begin : g_bad_depth
         $fatal(1, "anspwm_delay_line: DEPTH exceeds DELAY_MAX");
      end

      if (DEPTH == 0) begin : g_wire
         assign o_data = i_data;
         assign o_sgn  = i_sgn;
         assign o_vld  = i_vld;
      end else begin : g_pipe
         logic [WIDTH-1:0] r_data [DEPTH];
         logic             r_sgn  [DEPTH];
         logic             r_vld  [DEPTH];

         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               for (int unsigned k = 0; k < DEPTH; k++) begin
                  r_data[k] <= '0;
                  r_sgn[k]  <= 1'b0;
                  r_vld[k]  <= 1'b0;
               end
            end else begin
               r_vld[0] <= i_vld;
               if (i_vld) begin
                  r_data[0] <= i_data;
                  r_sgn[0]  <= i_sgn;
               end
               for (int unsigned k = 1; k < DEPTH; k++) begin
                  r_vld[k] <= r_vld[k-1];
                  if (r_vld[k-1]) begin
                     r_data[k] <= r_data[k-1];
                     r_sgn[k]  <= r_sgn[k-1];
                  end
               end
            end
         end

         assign o_data = r_data[DEPTH-1];
         assign o_sgn  = r_sgn[DEPTH-1];
         assign o_vld  = r_vld[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/anspwm_stage_p.sv
// ANS-PWM stage: quantise A, then delayed-difference of the residual as sign/magnitude.
// Define ANSPWM_SAT_EN to clamp the magnitude at 2^W-1 instead of wrapping.
module anspwm_stage_p
   import anspwm_pkg::*;
#(
   parameter int unsigned W     = 16,
   parameter int unsigned SHIFT = 8,
   parameter int unsigned ORDER = 2,
   parameter int unsigned DELAY = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   input  logic [W-1:0]   A,
   output logic [W-1:0]   quant,
   output logic [2*W-1:0] nxt_tgt,
   output logic           nxt_valid,
   output logic [W-1:0]   C,
   output logic           Csgn,
   output logic           out_valid
);

   localparam int unsigned   DW      = W + 3;
   localparam logic [W-1:0]  LO_MASK = {W{1'b1}} >> (W - SHIFT);

   generate
      if (ORDER != 32'(ORDER_1) && ORDER != 32'(ORDER_2)) begin : g_bad_order
         $fatal(1, "anspwm_stage_p: ORDER must be 1 or 2");
      end
      if (SHIFT < 1 || SHIFT > W) begin : g_bad_shift
         $fatal(1, "anspwm_stage_p: SHIFT must be in 1..W");
      end
      if (DELAY > DELAY_MAX) begin : g_bad_delay
         $fatal(1, "anspwm_stage_p: DELAY exceeds DELAY_MAX");
      end
      if (W > MAG_W_MAX) begin : g_bad_width
         $fatal(1, "anspwm_stage_p: W exceeds MAG_W_MAX");
      end
   endgenerate

   // quantise stage
   logic [W-1:0] r_quant;
   logic [W-1:0] r_res;
   logic         r_nv;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_quant <= '0;
         r_res   <= '0;
         r_nv    <= 1'b0;
      end else begin
         r_nv <= in_valid;
         if (in_valid) begin
            r_quant <= A & ~LO_MASK;
            r_res   <= A & LO_MASK;
         end
      end
   end

   assign quant     = r_quant;
   assign nxt_tgt   = {{W{1'b0}}, r_res};
   assign nxt_valid = r_nv;

   // difference stage; W+3 signed bits cover +/-2*(2^W-1) without overflow
   logic [W-1:0]          r_h1;
   logic [W-1:0]          r_h2;
   logic signed [DW-1:0]  w_r0;
   logic signed [DW-1:0]  w_r1;
   logic signed [DW-1:0]  w_r2;
   logic signed [DW-1:0]  w_d;
   logic                  w_neg;
   logic [DW-1:0]         w_abs;
   logic [W-1:0]          w_mag;

   assign w_r0  = signed'(DW'(r_res));
   assign w_r1  = signed'(DW'(r_h1));
   assign w_r2  = signed'(DW'(r_h2));
   assign w_d   = (ORDER == 32'(ORDER_1)) ? (w_r0 - w_r1) : (w_r0 - (w_r1 <<< 1) + w_r2);
   assign w_neg = w_d[DW-1];
   assign w_abs = w_neg ? unsigned'(-w_d) : unsigned'(w_d);

`ifdef ANSPWM_SAT_EN
   assign w_mag = (|w_abs[DW-1:W]) ? {W{1'b1}} : w_abs[W-1:0];
`else
   logic w_unused_abs;
   assign w_mag        = w_abs[W-1:0];
   assign w_unused_abs = |w_abs[DW-1:W];
`endif

   sgnmag_t r_diff;
   logic    r_dv;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_diff <= '0;
         r_dv   <= 1'b0;
         r_h1   <= '0;
         r_h2   <= '0;
      end else begin
         r_dv <= r_nv;
         if (r_nv) begin
            r_diff.sgn <= w_neg;
            r_diff.mag <= MAG_W_MAX'(w_mag);
            r_h1       <= r_res;
            r_h2       <= r_h1;
         end
      end
   end

   generate
      if (W < MAG_W_MAX) begin : g_hi
         logic w_unused_hi;
         assign w_unused_hi = |r_diff.mag[MAG_W_MAX-1:W];
      end
   endgenerate

   anspwm_delay_line #(
      .WIDTH (W),
      .DEPTH (DELAY)
   ) u_dly (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_data (r_diff.mag[W-1:0]),
      .i_sgn  (r_diff.sgn),
      .i_vld  (r_dv),
      .o_data (C),
      .o_sgn  (Csgn),
      .o_vld  (out_valid)
   );

endmodule

// File: tb/tb_anspwm_stage_p.sv
// Bench for anspwm_stage_p: three configurations checked against a sample-level model.
module tb_anspwm_stage_p;

   localparam int PW[3] = '{16, 16, 8};
   localparam int PS[3] = '{8, 8, 8};
   localparam int PO[3] = '{2, 1, 2};
   localparam int PD[3] = '{1, 0, 3};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        iv0 = 1'b0, iv1 = 1'b0, iv2 = 1'b0;
   logic [15:0] a0 = '0, a1 = '0;
   logic [7:0]  a2 = '0;
   logic [15:0] q0, q1, c0, c1;
   logic [31:0] nt0, nt1;
   logic [7:0]  q2, c2;
   logic [15:0] nt2;
   logic        nv0, nv1, nv2, cs0, cs1, cs2, ov0, ov1, ov2;

   anspwm_stage_p #(.W(PW[0]), .SHIFT(PS[0]), .ORDER(PO[0]), .DELAY(PD[0])) u_def (
      .clk(clk), .rst(rst), .in_valid(iv0), .A(a0), .quant(q0), .nxt_tgt(nt0),
      .nxt_valid(nv0), .C(c0), .Csgn(cs0), .out_valid(ov0));
   anspwm_stage_p #(.W(PW[1]), .SHIFT(PS[1]), .ORDER(PO[1]), .DELAY(PD[1])) u_o1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .A(a1), .quant(q1), .nxt_tgt(nt1),
      .nxt_valid(nv1), .C(c1), .Csgn(cs1), .out_valid(ov1));
   anspwm_stage_p #(.W(PW[2]), .SHIFT(PS[2]), .ORDER(PO[2]), .DELAY(PD[2])) u_w8 (
      .clk(clk), .rst(rst), .in_valid(iv2), .A(a2), .quant(q2), .nxt_tgt(nt2),
      .nxt_valid(nv2), .C(c2), .Csgn(cs2), .out_valid(ov2));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // reference model: per configuration, residual history and pending outputs by due cycle
   longint h1[3], h2[3];
   bit     pend_v[3][16];
   longint pend_c[3][16];
   bit     pend_s[3][16];
   longint exp_q[3], exp_nt[3], exp_c[3];
   bit     exp_nv[3], exp_ov[3], exp_cs[3];
   int     t = 0;

   task automatic model_edge(input int k, input bit rv, input bit v, input longint a);
      longint wmask, lo, res, d, mag;
      int slot, due;
      wmask = (longint'(1) << PW[k]) - 1;
      lo    = (longint'(1) << PS[k]) - 1;
      if (rv) begin
         h1[k] = 0; h2[k] = 0;
         for (int i = 0; i < 16; i++) pend_v[k][i] = 1'b0;
         exp_q[k] = 0; exp_nt[k] = 0; exp_c[k] = 0;
         exp_nv[k] = 1'b0; exp_ov[k] = 1'b0; exp_cs[k] = 1'b0;
         return;
      end
      slot = t % 16;
      exp_ov[k] = pend_v[k][slot];
      if (pend_v[k][slot]) begin
         exp_c[k]  = pend_c[k][slot];
         exp_cs[k] = pend_s[k][slot];
         pend_v[k][slot] = 1'b0;
      end
      exp_nv[k] = v;
      if (v) begin
         res = a & lo;
         exp_q[k]  = a & ~lo & wmask;
         exp_nt[k] = res;
         if (PO[k] == 1) d = res - h1[k];
         else            d = res - 2 * h1[k] + h2[k];
         mag = (d < 0) ? -d : d;
`ifdef ANSPWM_SAT_EN
         if (mag > wmask) mag = wmask;
`else
         mag = mag & wmask;
`endif
         h2[k] = h1[k];
         h1[k] = res;
         due = (t + 1 + PD[k]) % 16;
         pend_v[k][due] = 1'b1;
         pend_c[k][due] = mag;
         pend_s[k][due] = (d < 0);
      end
   endtask

   // per-phase capture of delivered outputs for directed literal checks
   longint cap_c[3][8];
   bit     cap_s[3][8];
   int     cap_n[3];
   int     cap_first[3];
   int     ph = 0;

   task automatic start_phase();
      ph = 0;
      for (int k = 0; k < 3; k++) begin
         cap_n[k] = 0;
         cap_first[k] = -1;
      end
   endtask

   task automatic capture(input int k, input bit ov, input longint c, input bit s);
      if (ov) begin
         if (cap_first[k] < 0) cap_first[k] = ph;
         if (cap_n[k] < 8) begin
            cap_c[k][cap_n[k]] = c;
            cap_s[k][cap_n[k]] = s;
         end
         cap_n[k]++;
      end
   endtask

   task automatic cycle(input bit rv, input bit v0, input logic [15:0] x0,
                        input bit v1, input logic [15:0] x1,
                        input bit v2, input logic [7:0] x2);
      @(negedge clk);
      rst = rv; iv0 = v0; a0 = x0; iv1 = v1; a1 = x1; iv2 = v2; a2 = x2;
      @(posedge clk);
      t++;
      ph++;
      model_edge(0, rv, v0, longint'(x0));
      model_edge(1, rv, v1, longint'(x1));
      model_edge(2, rv, v2, longint'(x2));
      #1;
      chk("q0", q0, exp_q[0]);   chk("nt0", nt0, exp_nt[0]); chk("nv0", nv0, exp_nv[0]);
      chk("ov0", ov0, exp_ov[0]); chk("c0", c0, exp_c[0]);   chk("cs0", cs0, exp_cs[0]);
      chk("q1", q1, exp_q[1]);   chk("nt1", nt1, exp_nt[1]); chk("nv1", nv1, exp_nv[1]);
      chk("ov1", ov1, exp_ov[1]); chk("c1", c1, exp_c[1]);   chk("cs1", cs1, exp_cs[1]);
      chk("q2", q2, exp_q[2]);   chk("nt2", nt2, exp_nt[2]); chk("nv2", nv2, exp_nv[2]);
      chk("ov2", ov2, exp_ov[2]); chk("c2", c2, exp_c[2]);   chk("cs2", cs2, exp_cs[2]);
      capture(0, ov0, longint'(c0), cs0);
      capture(1, ov1, longint'(c1), cs1);
      capture(2, ov2, longint'(c2), cs2);
   endtask

   localparam logic [15:0] T1[3] = '{16'hAB10, 16'h7730, 16'h0005};
   localparam logic [7:0]  T2[3] = '{8'hFF, 8'h00, 8'hFF};

   initial begin
      logic [15:0] r0, r1;
      logic [7:0]  r2;
      bit          rv;

      // reset held with full-scale valid input, then one quiet cycle
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 8'hFF);
         chk("rst_ov0", ov0, 0);
         chk("rst_q0", q0, 0);
      end
      cycle(1'b0, 1'b0, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 8'hFF);
      chk("post_rst_nv0", nv0, 0);

      // constant 0x1234 on defaults, short residual tables on the other two
      start_phase();
      for (int i = 0; i < 12; i++)
         cycle(1'b0, i < 6, 16'h1234, i < 3, T1[i % 3], i < 3, T2[i % 3]);
      chk("lat_def", cap_first[0], 3);
      chk("def_c0", cap_c[0][0], 'h34); chk("def_s0", cap_s[0][0], 0);
      chk("def_c1", cap_c[0][1], 'h34); chk("def_s1", cap_s[0][1], 1);
      chk("def_c2", cap_c[0][2], 'h00); chk("def_s2", cap_s[0][2], 0);
      chk("lat_o1", cap_first[1], 2);
      chk("o1_c0", cap_c[1][0], 'h10); chk("o1_s0", cap_s[1][0], 0);
      chk("o1_c1", cap_c[1][1], 'h20); chk("o1_s1", cap_s[1][1], 0);
      chk("o1_c2", cap_c[1][2], 'h2B); chk("o1_s2", cap_s[1][2], 1);
      chk("lat_w8", cap_first[2], 5);
`ifdef ANSPWM_SAT_EN
      chk("w8_c2", cap_c[2][2], 'hFF);
`else
      chk("w8_c2", cap_c[2][2], 'hFE);
`endif
      chk("w8_s2", cap_s[2][2], 0);

      // gap: history must freeze across idle cycles
      cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
      start_phase();
      for (int i = 0; i < 10; i++)
         cycle(1'b0, (i < 2) || (i == 5), 16'h1234, 1'b0, '0, 1'b0, '0);
      chk("gap_n", cap_n[0], 3);
      chk("gap_c2", cap_c[0][2], 'h00);
      chk("gap_s2", cap_s[0][2], 0);

      // mid-stream reset discards in-flight samples and history
      for (int i = 0; i < 5; i++)
         cycle(1'b0, 1'b1, 16'($urandom), 1'b1, 16'($urandom), 1'b1, 8'($urandom));
      cycle(1'b1, 1'b1, 16'h5555, 1'b1, 16'h5555, 1'b1, 8'h55);
      cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
      chk("mid_ov0", ov0, 0);
      start_phase();
      for (int i = 0; i < 5; i++)
         cycle(1'b0, i == 0, 16'h1234, 1'b0, '0, 1'b0, '0);
      chk("mid_c0", cap_c[0][0], 'h34);
      chk("mid_s0", cap_s[0][0], 0);

      // random traffic with sparse resets
      for (int i = 0; i < 400; i++) begin
         r0 = 16'($urandom); r1 = 16'($urandom); r2 = 8'($urandom);
         rv = ($urandom_range(0, 39) == 0);
         cycle(rv, $urandom_range(0, 3) != 0, r0, $urandom_range(0, 3) != 0, r1,
               $urandom_range(0, 3) != 0, r2);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
